// File: rtl/lane_judge_scorer.sv
// Strum judge: opens a timing window per note, grades the strum against the latched chord,
// and keeps a saturating score with a streak-driven multiplier.
module lane_judge_scorer #(
   parameter int unsigned LANES             = 5,
   parameter int unsigned WINDOW_CYCLES     = 8,
   parameter int unsigned BASE_POINTS       = 10,
   parameter int unsigned STREAK_STEP       = 4,
   parameter int unsigned MAX_MULT          = 4,
   parameter int unsigned SCORE_W           = 21,
   parameter int unsigned OVERSTRUM_PENALTY = 1
) (
   input  logic                              clk,
   input  logic                              reset_n,
   input  logic                              stop,
   input  logic                              pause,
   input  logic                              note_valid,
   input  logic [LANES-1:0]                  notes_to_play,
   input  logic [LANES-1:0]                  buttons,
   input  logic                              strum,
   output logic                              note_hit,
   output logic                              note_miss,
   output logic [SCORE_W-1:0]                score,
   output logic [15:0]                       streak,
   output logic [$clog2(MAX_MULT+1)-1:0]     multiplier,
   output logic                              window_open
);

   localparam int unsigned MultW = $clog2(MAX_MULT + 1);
   localparam int unsigned CntW  = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
   localparam int unsigned SumW  = SCORE_W + 32;

   typedef enum logic [0:0] {StIdle, StArmed} state_e;

   state_e             state_q;
   logic [LANES-1:0]   pattern_q;
   logic [CntW-1:0]    cnt_q;
   logic               strum_q;
   logic [SCORE_W-1:0] score_q;
   logic [15:0]        streak_q;
   logic [MultW-1:0]   mult_q;
   logic               hit_q, miss_q;

   logic               strum_rise, new_note, hit, miss;
   logic [SumW-1:0]    sum;
   logic [SCORE_W-1:0] score_hit;
   logic [15:0]        streak_hit;
   logic [MultW-1:0]   mult_hit;
   int unsigned        mult_calc;

   // Judgement for the upcoming edge; a zero chord is not treated as a note.
   always_comb begin
      strum_rise = strum & ~strum_q & ~pause;
      new_note   = note_valid & ~pause & (|notes_to_play);
      hit        = 1'b0;
      miss       = 1'b0;
      if (!pause) begin
         unique case (state_q)
            StIdle: begin
               if (strum_rise) begin
                  if (new_note) begin
                     hit  = (buttons == notes_to_play);
                     miss = ~hit;
                  end else begin
                     miss = (OVERSTRUM_PENALTY != 0);
                  end
               end
            end
            StArmed: begin
               if (strum_rise) begin
                  hit  = (buttons == pattern_q);
                  miss = ~hit;
               end else begin
                  miss = new_note || (cnt_q == '0);
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      sum        = SumW'(score_q) + SumW'(BASE_POINTS) * SumW'(mult_q);
      score_hit  = (|sum[SumW-1:SCORE_W]) ? '1 : sum[SCORE_W-1:0];
      streak_hit = (&streak_q) ? streak_q : streak_q + 16'd1;
      mult_calc  = 32'(streak_hit) / STREAK_STEP + 1;
      mult_hit   = (mult_calc > MAX_MULT) ? MultW'(MAX_MULT) : MultW'(mult_calc);
   end

   always_ff @(posedge clk) begin
      if (!reset_n || stop) begin
         state_q   <= StIdle;
         pattern_q <= '0;
         cnt_q     <= '0;
         strum_q   <= 1'b0;
         score_q   <= '0;
         streak_q  <= '0;
         mult_q    <= MultW'(1);
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
      end else begin
         strum_q <= strum;
         hit_q   <= hit;
         miss_q  <= miss;
         if (hit) begin
            score_q  <= score_hit;
            streak_q <= streak_hit;
            mult_q   <= mult_hit;
         end else if (miss) begin
            streak_q <= '0;
            mult_q   <= MultW'(1);
         end
         if (!pause) begin
            unique case (state_q)
               StIdle: begin
                  // A strum in the same cycle consumes the incoming note immediately.
                  if (new_note && !strum_rise) begin
                     state_q   <= StArmed;
                     pattern_q <= notes_to_play;
                     cnt_q     <= CntW'(WINDOW_CYCLES - 1);
                  end
               end
               StArmed: begin
                  if (new_note) begin
                     pattern_q <= notes_to_play;
                     cnt_q     <= CntW'(WINDOW_CYCLES - 1);
                  end else if (strum_rise || cnt_q == '0) begin
                     state_q <= StIdle;
                  end else begin
                     cnt_q <= cnt_q - CntW'(1);
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign note_hit    = hit_q;
   assign note_miss   = miss_q;
   assign score       = score_q;
   assign streak      = streak_q;
   assign multiplier  = mult_q;
   assign window_open = (state_q == StArmed);

endmodule

// File: tb/tb_lane_judge_scorer.sv
// Randomised bench for lane_judge_scorer: two configurations share stimulus; a deadline-based
// note model feeds a pulse scoreboard and per-edge expectations for the score outputs.
module tb_lane_judge_scorer;

   localparam int NE = 8192;
   localparam int unsigned CfgWin  [2] = '{8, 3};
   localparam int unsigned CfgBase [2] = '{10, 10};
   localparam int unsigned CfgStep [2] = '{4, 2};
   localparam int unsigned CfgMax  [2] = '{4, 1};
   localparam int unsigned CfgSw   [2] = '{21, 6};
   localparam int unsigned CfgOver [2] = '{1, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, stop, pause, note_valid, strum;
   logic [4:0] notes_to_play, buttons;

   logic hit0, miss0, win0, hit1, miss1, win1;
   logic [20:0] score0;
   logic [5:0]  score1;
   logic [15:0] streak0, streak1;
   logic [2:0]  mult0;
   logic [0:0]  mult1;

   lane_judge_scorer u_dut0 (
      .clk(clk), .reset_n(reset_n), .stop(stop), .pause(pause), .note_valid(note_valid),
      .notes_to_play(notes_to_play), .buttons(buttons), .strum(strum), .note_hit(hit0),
      .note_miss(miss0), .score(score0), .streak(streak0), .multiplier(mult0),
      .window_open(win0)
   );

   lane_judge_scorer #(
      .LANES(5), .WINDOW_CYCLES(3), .BASE_POINTS(10), .STREAK_STEP(2), .MAX_MULT(1),
      .SCORE_W(6), .OVERSTRUM_PENALTY(0)
   ) u_dut1 (
      .clk(clk), .reset_n(reset_n), .stop(stop), .pause(pause), .note_valid(note_valid),
      .notes_to_play(notes_to_play), .buttons(buttons), .strum(strum), .note_hit(hit1),
      .note_miss(miss1), .score(score1), .streak(streak1), .multiplier(mult1),
      .window_open(win1)
   );

   typedef struct {int ecnt; bit hit;} exp_t;
   exp_t q0[$];
   exp_t q1[$];

   int checks = 0;
   int errors = 0;
   int ecnt = 0;
   always @(posedge clk) ecnt <= ecnt + 1;

   // Model: a pending note carries the last edge at which it may still be judged.
   bit       m_sq;
   bit       m_act [2];
   bit [4:0] m_pat [2];
   int       m_dead [2];
   int       m_score [2];
   int       m_streak [2];
   int       m_mult [2];
   bit       exp_ok [NE];
   int       exp_win [2][NE];
   int       exp_sc [2][NE];
   int       exp_st [2][NE];
   int       exp_mu [2][NE];

   task automatic cmp(string name, int u, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s unit%0d edge %0d: got %0d expected %0d", name, u, ecnt, act, exp);
      end
   endtask

   task automatic judge(int u, int e, bit h);
      exp_t x;
      int smax;
      smax = (1 << CfgSw[u]) - 1;
      if (h) begin
         m_score[u] = m_score[u] + int'(CfgBase[u]) * m_mult[u];
         if (m_score[u] > smax) m_score[u] = smax;
         if (m_streak[u] < 65535) m_streak[u]++;
         m_mult[u] = 1 + m_streak[u] / int'(CfgStep[u]);
         if (m_mult[u] > int'(CfgMax[u])) m_mult[u] = int'(CfgMax[u]);
      end else begin
         m_streak[u] = 0;
         m_mult[u]   = 1;
      end
      x.ecnt = e;
      x.hit  = h;
      if (u == 0) q0.push_back(x);
      else q1.push_back(x);
   endtask

   task automatic load(int u, int e);
      m_act[u]  = 1'b1;
      m_pat[u]  = notes_to_play;
      m_dead[u] = e + int'(CfgWin[u]);
   endtask

   task automatic unit_step(int u, int e, bit rise, bit newn);
      bit consumed;
      consumed = 1'b0;
      if (pause) begin
         if (m_act[u]) m_dead[u]++;
      end else if (rise) begin
         if (m_act[u]) judge(u, e, buttons == m_pat[u]);
         else if (newn) begin
            judge(u, e, buttons == notes_to_play);
            consumed = 1'b1;
         end else if (CfgOver[u] != 0) judge(u, e, 1'b0);
         m_act[u] = 1'b0;
         if (newn && !consumed) load(u, e);
      end else if (newn) begin
         if (m_act[u]) judge(u, e, 1'b0);
         load(u, e);
      end else if (m_act[u] && e == m_dead[u]) begin
         judge(u, e, 1'b0);
         m_act[u] = 1'b0;
      end
   endtask

   // Predicts the effect of the next clock edge, then waits for it.
   task automatic step();
      int  e;
      bit  rise, newn;
      e    = ecnt + 1;
      rise = strum && !m_sq;
      newn = note_valid && (notes_to_play != 5'd0);
      if (!reset_n || stop) begin
         m_sq = 1'b0;
         for (int u = 0; u < 2; u++) begin
            m_act[u] = 1'b0; m_score[u] = 0; m_streak[u] = 0; m_mult[u] = 1;
         end
      end else begin
         m_sq = strum;
         for (int u = 0; u < 2; u++) unit_step(u, e, rise, newn);
      end
      if (e < NE) begin
         exp_ok[e] = 1'b1;
         for (int u = 0; u < 2; u++) begin
            exp_win[u][e] = int'(m_act[u]);
            exp_sc[u][e]  = m_score[u];
            exp_st[u][e]  = m_streak[u];
            exp_mu[u][e]  = m_mult[u];
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_unit(int u, logic h, logic m, logic w, logic [31:0] sc,
                             logic [31:0] st, logic [31:0] mu);
      exp_t x;
      int   qn;
      if (ecnt < NE && exp_ok[ecnt]) begin
         cmp("window_open", u, {31'd0, w}, exp_win[u][ecnt]);
         cmp("score", u, sc, exp_sc[u][ecnt]);
         cmp("streak", u, st, exp_st[u][ecnt]);
         cmp("multiplier", u, mu, exp_mu[u][ecnt]);
      end
      qn = (u == 0) ? q0.size() : q1.size();
      if (h === 1'b1 && m === 1'b1) cmp("hit_and_miss", u, 32'd1, 32'd0);
      if (h === 1'b1 || m === 1'b1) begin
         if (qn == 0) cmp("spurious_pulse", u, 32'd1, 32'd0);
         else begin
            x = (u == 0) ? q0.pop_front() : q1.pop_front();
            cmp("pulse_edge", u, ecnt, x.ecnt);
            cmp("pulse_is_hit", u, {31'd0, h}, {31'd0, x.hit});
         end
      end else if (qn != 0) begin
         x = (u == 0) ? q0[0] : q1[0];
         if (x.ecnt <= ecnt) begin
            cmp("missing_pulse", u, 32'd0, {31'd0, x.hit} + 32'd1);
            if (u == 0) void'(q0.pop_front());
            else void'(q1.pop_front());
         end
      end
   endtask

   always @(negedge clk) begin
      check_unit(0, hit0, miss0, win0, 32'(score0), 32'(streak0), 32'(mult0));
      check_unit(1, hit1, miss1, win1, 32'(score1), 32'(streak1), 32'(mult1));
   end

   task automatic idle(int n);
      note_valid = 1'b0;
      strum      = 1'b0;
      repeat (n) step();
   endtask

   int pause_left = 0;

   initial begin
      reset_n = 1'b0; stop = 1'b0; pause = 1'b0; note_valid = 1'b0;
      notes_to_play = '0; buttons = '0; strum = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;
      // Single hit three cycles into the window.
      note_valid = 1'b1; notes_to_play = 5'b00101; step();
      note_valid = 1'b0; buttons = 5'b00101; step(); step();
      strum = 1'b1; step();
      idle(3);
      // Run of correct hits to reach the multiplier step.
      for (int i = 0; i < 5; i++) begin
         note_valid = 1'b1; notes_to_play = 5'b01011; buttons = 5'b01011; step();
         note_valid = 1'b0; step();
         strum = 1'b1; step();
         idle(1);
      end
      // Expiry, wrong chord and overstrum.
      note_valid = 1'b1; notes_to_play = 5'b10000; step();
      idle(12);
      note_valid = 1'b1; buttons = 5'b01000; step();
      note_valid = 1'b0; strum = 1'b1; step();
      idle(2);
      strum = 1'b1; step();
      idle(2);
      // Pause mid-window with a strum held across the release.
      note_valid = 1'b1; notes_to_play = 5'b00110; buttons = 5'b00110; step();
      note_valid = 1'b0; step(); step();
      pause = 1'b1;
      repeat (5) step();
      strum = 1'b1;
      repeat (15) step();
      pause = 1'b0; step();
      strum = 1'b0; step();
      strum = 1'b1; step();
      idle(10);
      // Back-to-back notes, then a same-cycle note and strum.
      note_valid = 1'b1; notes_to_play = 5'b11000; step();
      idle(3);
      note_valid = 1'b1; notes_to_play = 5'b00011; step();
      idle(12);
      note_valid = 1'b1; notes_to_play = 5'b10101; buttons = 5'b10101; strum = 1'b1; step();
      idle(3);
      // Reset and stop in the middle of an open window.
      note_valid = 1'b1; step(); note_valid = 1'b0; step();
      stop = 1'b1; step(); stop = 1'b0;
      idle(4);
      note_valid = 1'b1; step(); note_valid = 1'b0; step();
      reset_n = 1'b0; step(); reset_n = 1'b1;
      idle(4);
      for (int i = 0; i < 5000; i++) begin
         note_valid    = ($urandom_range(0, 6) == 0);
         notes_to_play = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
         if ($urandom_range(0, 3) == 0) strum = ~strum;
         if ($urandom_range(0, 9) < 7) buttons = m_act[0] ? m_pat[0] : notes_to_play;
         else buttons = 5'($urandom_range(0, 31));
         if (pause_left > 0) pause_left--;
         else if ($urandom_range(0, 80) == 0) pause_left = $urandom_range(1, 20);
         pause   = (pause_left > 0);
         stop    = ($urandom_range(0, 700) == 0);
         reset_n = ($urandom_range(0, 1500) != 0);
         step();
      end
      reset_n = 1'b1; stop = 1'b0; pause = 1'b0;
      idle(15);
      cmp("drain_q", 0, q0.size(), 32'd0);
      cmp("drain_q", 1, q1.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
